// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// the value returned by a rejected load, and the byte-address to word-index helper.
// No ports. Optional error checking in dmem_responder is enabled by DMEM_ERR_CHECK_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;

  // Byte address to word index. Callers keep only the low ADDR_BITS bits,
  // which is what makes the array wrap modulo its depth.
  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered read port.
// Ports: clk, rst (sync, active-high, clears only the read register), we/re enables,
//        idx word index, wdata store data, rdata holds the last read until the next re.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder on the MEM-stage port: accepts one load or store,
// stalls the pipeline for LATENCY cycles and acknowledges for one cycle after that.
// Ports: clk_i, rst_i (sync, active-high), MemRead_i/MemWrite_i requests, addr_i byte address,
//        data_i store data, data_o last load result, stall_o pipeline freeze, ack_o completion,
//        err_o only when DMEM_ERR_CHECK_EN is defined (misaligned / out-of-range / read+write).
import dmem_pkg::*;

module dmem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o
`ifdef DMEM_ERR_CHECK_EN
  ,
  output logic        err_o
`endif
);

  state_t               state;
  logic [3:0]           cnt;
  logic                 lat_wr;
  logic [ADDR_BITS-1:0] lat_idx;
  logic [31:0]          lat_dat;
  logic                 lat_err;
  logic                 rd_err;

  logic                 req;
  logic                 in_idle;
  logic                 fire;
  logic                 live_err;
  logic                 acc_wr;
  logic                 acc_err;
  logic [29:0]          widx;
  logic [ADDR_BITS-1:0] live_idx;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [31:0]          acc_dat;
  logic                 mem_we;
  logic                 mem_re;
  logic [31:0]          rdata;

  assign widx     = word_idx(addr_i);
  assign live_idx = widx[ADDR_BITS-1:0];
  assign req      = MemRead_i | MemWrite_i;
  assign in_idle  = (state == IDLE);

`ifdef DMEM_ERR_CHECK_EN
  assign live_err = (addr_i[1:0] != 2'b00) | (widx[29:ADDR_BITS] != '0) | (MemRead_i & MemWrite_i);
  assign err_o    = lat_err;
`else
  assign live_err = 1'b0;
  logic unused_hi;
  assign unused_hi = ^widx[29:ADDR_BITS];
`endif

  // With LATENCY=1 the access fires straight out of IDLE, before the latches
  // are loaded, so the live inputs feed the array in that case.
  assign acc_wr  = in_idle ? MemWrite_i : lat_wr;
  assign acc_idx = in_idle ? live_idx   : lat_idx;
  assign acc_dat = in_idle ? data_i     : lat_dat;
  assign acc_err = in_idle ? live_err   : lat_err;

  // cnt is loaded with LATENCY-1 and reaches 0 on the edge into DONE, so the
  // last BUSY cycle is the one that sees cnt==1.
  assign fire = in_idle ? (req && (LATENCY == 1))
                        : ((state == BUSY) && (cnt == 4'd1));

  // Reset wins over a completing access: a pending store never lands.
  assign mem_we = fire &  acc_wr & ~acc_err & ~rst_i;
  assign mem_re = fire & ~acc_wr & ~acc_err & ~rst_i;

  assign stall_o = (in_idle & req) | (state == BUSY);
  assign ack_o   = (state == DONE);
  assign data_o  = rd_err ? DMEM_ERR_DATA : rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_wr  <= 1'b0;
      lat_idx <= '0;
      lat_dat <= '0;
      lat_err <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      if (fire && !acc_wr) begin
        rd_err <= acc_err;
      end
      case (state)
        IDLE: begin
          if (req) begin
            // A simultaneous read and write is handled as a store.
            lat_wr  <= MemWrite_i;
            lat_idx <= live_idx;
            lat_dat <= data_i;
            lat_err <= live_err;
            if (LATENCY > 1) begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end else begin
              state <= DONE;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          // The request still on the inputs is the one just completed.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_array (
    .clk  (clk_i),
    .rst  (rst_i),
    .we   (mem_we),
    .re   (mem_re),
    .idx  (acc_idx),
    .wdata(acc_dat),
    .rdata(rdata)
  );

endmodule
